// File: rtl/ahb_dma_copy.sv
// rtl/ahb_dma_copy.sv - AHB-Lite initiator copying a block of 32-bit words from src to dst
// One NONSEQ SINGLE read then one NONSEQ SINGLE write per word; never two transfers outstanding.
module ahb_dma_copy #(
  parameter int LEN_W = 16
) (
  input  logic             I_ahb_clk,
  input  logic             I_rst,
  input  logic             I_start,
  input  logic [31:0]      I_src_addr,
  input  logic [31:0]      I_dst_addr,
  input  logic [LEN_W-1:0] I_len,
  output logic             O_busy,
  output logic             O_done,
  output logic             O_err,
  output logic [31:0]      O_err_addr,
  output logic [1:0]       O_ahb_htrans,
  output logic             O_ahb_hwrite,
  output logic [31:0]      O_ahb_haddr,
  output logic [2:0]       O_ahb_hsize,
  output logic [2:0]       O_ahb_hburst,
  output logic [3:0]       O_ahb_hprot,
  output logic             O_ahb_hmastlock,
  output logic [31:0]      O_ahb_hwdata,
  input  logic [31:0]      I_ahb_hrdata,
  input  logic [1:0]       I_ahb_hresp,
  input  logic             I_ahb_hready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_ADDR,
    S_WR_DATA,
    S_ERR,
    S_DONE
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  state_t r_state;
  state_t w_next;

  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [31:0]      r_haddr;
  logic [31:0]      r_data;
  logic [31:0]      r_hwdata;
  logic [31:0]      r_err_addr;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;
  logic             r_hwrite;
  logic             r_err;

  logic [31:0]      w_src_aligned;
  logic [31:0]      w_dst_aligned;
  logic [31:0]      w_src_inc;
  logic [31:0]      w_dst_inc;
  logic [LEN_W-1:0] w_count_inc;
  logic             w_resp_err;
  logic             w_accept;
  logic             w_rd_cap;
  logic             w_wr_ok;
  logic             w_err_hit;
  logic [1:0]       w_htrans;

  assign w_src_aligned = I_src_addr & 32'hFFFF_FFFC;
  assign w_dst_aligned = I_dst_addr & 32'hFFFF_FFFC;
  assign w_src_inc     = r_src + 32'd4;
  assign w_dst_inc     = r_dst + 32'd4;
  assign w_count_inc   = r_count + LEN_W'(1);
  assign w_resp_err    = (I_ahb_hresp == HRESP_ERROR);

  always_ff @(posedge I_ahb_clk) begin
    if (I_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_htrans  = HTRANS_IDLE;
    w_accept  = 1'b0;
    w_rd_cap  = 1'b0;
    w_wr_ok   = 1'b0;
    w_err_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (I_start) begin
          w_accept = 1'b1;
          w_next   = (I_len == '0) ? S_DONE : S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        w_htrans = HTRANS_NONSEQ;
        if (I_ahb_hready) begin
          w_next = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        // An ERROR seen with hready low is the first cycle of the two-cycle response.
        if (w_resp_err) begin
          w_err_hit = 1'b1;
          w_next    = I_ahb_hready ? S_DONE : S_ERR;
        end else if (I_ahb_hready) begin
          w_rd_cap = 1'b1;
          w_next   = S_WR_ADDR;
        end
      end
      S_WR_ADDR: begin
        w_htrans = HTRANS_NONSEQ;
        if (I_ahb_hready) begin
          w_next = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (w_resp_err) begin
          w_err_hit = 1'b1;
          w_next    = I_ahb_hready ? S_DONE : S_ERR;
        end else if (I_ahb_hready) begin
          w_wr_ok = 1'b1;
          w_next  = (w_count_inc == r_len) ? S_DONE : S_RD_ADDR;
        end
      end
      S_ERR: begin
        if (I_ahb_hready) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge I_ahb_clk) begin
    if (I_rst) begin
      r_src      <= '0;
      r_dst      <= '0;
      r_len      <= '0;
      r_count    <= '0;
      r_haddr    <= '0;
      r_hwrite   <= 1'b0;
      r_data     <= '0;
      r_hwdata   <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      if (w_accept) begin
        r_src      <= w_src_aligned;
        r_dst      <= w_dst_aligned;
        r_len      <= I_len;
        r_count    <= '0;
        r_err      <= 1'b0;
        r_err_addr <= '0;
        if (I_len != '0) begin
          r_haddr  <= w_src_aligned;
          r_hwrite <= 1'b0;
        end
      end
      // Address/direction are loaded on entry to an address phase and held otherwise.
      if (w_rd_cap) begin
        r_data   <= I_ahb_hrdata;
        r_haddr  <= r_dst;
        r_hwrite <= 1'b1;
      end
      if (r_state == S_WR_ADDR && I_ahb_hready) begin
        r_hwdata <= r_data;
      end
      if (w_wr_ok) begin
        r_count <= w_count_inc;
        r_src   <= w_src_inc;
        r_dst   <= w_dst_inc;
        if (w_count_inc != r_len) begin
          r_haddr  <= w_src_inc;
          r_hwrite <= 1'b0;
        end
      end
      if (w_err_hit) begin
        r_err      <= 1'b1;
        r_err_addr <= r_haddr;
      end
    end
  end

  assign O_busy          = (r_state != S_IDLE);
  assign O_done          = (r_state == S_DONE);
  assign O_err           = r_err;
  assign O_err_addr      = r_err_addr;
  assign O_ahb_htrans    = w_htrans;
  assign O_ahb_hwrite    = r_hwrite;
  assign O_ahb_haddr     = r_haddr;
  assign O_ahb_hsize     = 3'b010;
  assign O_ahb_hburst    = 3'b000;
  assign O_ahb_hprot     = 4'b0011;
  assign O_ahb_hmastlock = 1'b0;
  assign O_ahb_hwdata    = r_hwdata;

endmodule
